// File: rtl/spn_cu_pkg.sv
// Shared types and helpers for the SPN core arbiter slice.
package spn_cu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned KEY_W  = 32;

    typedef enum logic [1:0] {
        no_op   = 2'd0,
        encrypt = 2'd1,
        decrypt = 2'd2
    } opcode_t;

    typedef enum logic [1:0] {
        no_status             = 2'd0,
        successful_encryption = 2'd1,
        successful_decryption = 2'd2,
        core_fault            = 2'd3
    } valid_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    function automatic valid_t expected_status(input opcode_t op);
        valid_t st;
        case (op)
            encrypt: st = successful_encryption;
            decrypt: st = successful_decryption;
            default: st = no_status;
        endcase
        return st;
    endfunction

    function automatic logic is_crypto_op(input opcode_t op);
        return (op == encrypt) || (op == decrypt);
    endfunction

endpackage

// File: rtl/spn_rr_picker.sv
// Combinational round-robin pick: first set request at or above rr_ptr, wrapping.
module spn_rr_picker #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] grant,
    output logic             any
);

    always_comb begin
        int unsigned idx;
        idx   = 0;
        grant = '0;
        any   = 1'b0;
        for (int unsigned ofs = 0; ofs < N_REQ; ofs++) begin
            idx = 32'(rr_ptr) + ofs;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!any && req[IDX_W'(idx)]) begin
                any   = 1'b1;
                grant = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/spn_cu_arbiter.sv
// Round-robin arbiter sequencing N_REQ requesters onto one SPN core.
// Define SPN_ARB_TIMEOUT_EN to poll core status every WAIT cycle with a TIMEOUT bound.
module spn_cu_arbiter
    import spn_cu_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned CORE_LAT = 2,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  opcode_t [N_REQ-1:0]            req_opcode,
    input  logic [N_REQ-1:0][DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0][KEY_W-1:0]    req_key,
    output logic [N_REQ-1:0]               rsp_valid,
    output logic [DATA_W-1:0]              rsp_data,
    output logic                           rsp_err,
    output opcode_t                        core_opcode,
    output logic [DATA_W-1:0]              core_data_in,
    output logic [KEY_W-1:0]               core_key,
    input  valid_t                         core_valid,
    input  logic [DATA_W-1:0]              core_data_out,
    output logic                           busy
);

    localparam int unsigned IDX_W   = $clog2(N_REQ);
    localparam int unsigned CNT_MAX = (TIMEOUT > CORE_LAT) ? TIMEOUT : CORE_LAT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    arb_state_t state_q, state_d;

    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  gnt_q, gnt_d;
    opcode_t           cap_op_q, cap_op_d;
    logic [DATA_W-1:0] cap_data_q, cap_data_d;
    logic [KEY_W-1:0]  cap_key_q, cap_key_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    opcode_t           core_op_q, core_op_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              busy_q, busy_d;

    logic [IDX_W-1:0]  grant_c;
    logic              any_c;
    logic              sample_c;
    logic              hit_c;
    logic              done_c;

    spn_rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req    (req_valid),
        .rr_ptr (rr_ptr_q),
        .grant  (grant_c),
        .any    (any_c)
    );

    // Status sampling: one fixed sample, or polling from CORE_LAT-1 up to TIMEOUT.
`ifdef SPN_ARB_TIMEOUT_EN
    assign sample_c = (wait_cnt_q >= CNT_W'(CORE_LAT - 1));
    assign hit_c    = sample_c && (core_valid == expected_status(cap_op_q));
    assign done_c   = hit_c || (wait_cnt_q == CNT_W'(TIMEOUT));
`else
    assign sample_c = (wait_cnt_q == CNT_W'(CORE_LAT - 1));
    assign hit_c    = sample_c && (core_valid == expected_status(cap_op_q));
    assign done_c   = sample_c;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Illegal opcodes bypass WAIT so the core never sees them.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (any_c) state_d = ST_ISSUE;
            ST_ISSUE: state_d = is_crypto_op(cap_op_q) ? ST_WAIT : ST_RESP;
            ST_WAIT:  if (done_c) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = '0;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        cap_op_d    = cap_op_q;
        cap_data_d  = cap_data_q;
        cap_key_d   = cap_key_q;
        wait_cnt_d  = wait_cnt_q;
        core_op_d   = core_op_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        busy_d      = (state_d != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (any_c) begin
                    // Handshake stays closed while reset is held.
                    req_ready[grant_c] = rst;
                    gnt_d      = grant_c;
                    cap_op_d   = req_opcode[grant_c];
                    cap_data_d = req_data[grant_c];
                    cap_key_d  = req_key[grant_c];
                    core_op_d  = is_crypto_op(req_opcode[grant_c]) ? req_opcode[grant_c] : no_op;
                end
            end
            ST_ISSUE: begin
                wait_cnt_d = '0;
                if (!is_crypto_op(cap_op_q)) begin
                    rsp_valid_d[gnt_q] = 1'b1;
                    rsp_data_d         = '0;
                    rsp_err_d          = 1'b1;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q < CNT_W'(CNT_MAX)) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
                if (done_c) begin
                    core_op_d          = no_op;
                    rsp_valid_d[gnt_q] = 1'b1;
                    rsp_data_d         = hit_c ? core_data_out : '0;
                    rsp_err_d          = !hit_c;
                end
            end
            ST_RESP: begin
                rr_ptr_d = (gnt_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);
            end
            default: begin
                core_op_d = no_op;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            cap_op_q    <= no_op;
            cap_data_q  <= '0;
            cap_key_q   <= '0;
            wait_cnt_q  <= '0;
            core_op_q   <= no_op;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            cap_op_q    <= cap_op_d;
            cap_data_q  <= cap_data_d;
            cap_key_q   <= cap_key_d;
            wait_cnt_q  <= wait_cnt_d;
            core_op_q   <= core_op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_err      = rsp_err_q;
    assign core_opcode  = core_op_q;
    assign core_data_in = cap_data_q;
    assign core_key     = cap_key_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_spn_cu_arbiter.sv
// Directed bench for spn_cu_arbiter with a small latency-accurate core model.
module tb_spn_cu_arbiter;
    import spn_cu_pkg::*;

    localparam int unsigned N   = 4;
    localparam int unsigned LAT = 2;
    localparam int unsigned TMO = 15;
`ifdef SPN_ARB_TIMEOUT_EN
    localparam int BAD_LAT = TMO + 3;
`else
    localparam int BAD_LAT = LAT + 2;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    opcode_t [N-1:0]      req_opcode;
    logic [N-1:0][15:0]   req_data;
    logic [N-1:0][31:0]   req_key;
    logic [N-1:0]         rsp_valid;
    logic [15:0]          rsp_data;
    logic                 rsp_err;
    opcode_t              core_opcode;
    logic [15:0]          core_data_in;
    logic [31:0]          core_key;
    valid_t               core_valid;
    logic [15:0]          core_data_out;
    logic                 busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic force_bad = 1'b0;
    logic stall     = 1'b0;
    int   age;

    logic [15:0] wave_pt  [4];
    logic [15:0] wave_exp [2][4];

    always #5 clk = ~clk;

    spn_cu_arbiter #(
        .N_REQ    (N),
        .CORE_LAT (LAT),
        .TIMEOUT  (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_opcode    (req_opcode),
        .req_data      (req_data),
        .req_key       (req_key),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .core_opcode   (core_opcode),
        .core_data_in  (core_data_in),
        .core_key      (core_key),
        .core_valid    (core_valid),
        .core_data_out (core_data_out),
        .busy          (busy)
    );

    // Toy reversible cipher: xor low key half, add high key half, rotate left one nibble.
    function automatic logic [15:0] model_enc(input logic [15:0] p, input logic [31:0] k);
        logic [15:0] t;
        t = (p ^ k[15:0]) + k[31:16];
        return {t[11:0], t[15:12]};
    endfunction

    function automatic logic [15:0] model_dec(input logic [15:0] c, input logic [31:0] k);
        logic [15:0] t;
        t = {c[3:0], c[15:4]};
        return (t - k[31:16]) ^ k[15:0];
    endfunction

    // Core result appears LAT cycles after its inputs are first applied.
    always @(posedge clk or negedge rst) begin
        if (!rst)                     age <= 0;
        else if (core_opcode == no_op) age <= 0;
        else if (age < 1000)           age <= age + 1;
    end

    always_comb begin
        core_valid    = no_status;
        core_data_out = 16'h0000;
        if (core_opcode != no_op && age >= int'(LAT) && !stall) begin
            if (core_opcode == encrypt) begin
                core_data_out = model_enc(core_data_in, core_key);
                core_valid    = force_bad ? successful_decryption : successful_encryption;
            end else begin
                core_data_out = model_dec(core_data_in, core_key);
                core_valid    = force_bad ? successful_encryption : successful_decryption;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a grant to idx, finish the handshake, then check the response and its latency.
    task automatic serve(input int idx, input opcode_t iss_op, input logic [15:0] exp_d,
                         input logic exp_e, input int exp_lat, input string tag);
        logic [N-1:0] one;
        int n;
        one = N'(1) << idx;
        #1;
        n = 0;
        while (req_ready == '0 && n < 40) begin
            tick();
            n++;
        end
        chk($sformatf("%s ready", tag), 32'(req_ready), 32'(one));
        tick();
        req_valid[idx] = 1'b0;
        if (iss_op != no_op) begin
            chk($sformatf("%s core_din", tag), 32'(core_data_in), 32'(req_data[idx]));
            chk($sformatf("%s core_key", tag), core_key, req_key[idx]);
        end
        n = 1;
        while (rsp_valid == '0 && n < 40) begin
            chk($sformatf("%s core_op c%0d", tag, n), 32'(core_opcode), 32'(iss_op));
            tick();
            n++;
        end
        chk($sformatf("%s latency", tag), 32'(n), 32'(exp_lat));
        chk($sformatf("%s rsp_valid", tag), 32'(rsp_valid), 32'(one));
        chk($sformatf("%s rsp_data", tag), 32'(rsp_data), 32'(exp_d));
        chk($sformatf("%s rsp_err", tag), 32'(rsp_err), 32'(exp_e));
        chk($sformatf("%s core_op resp", tag), 32'(core_opcode), 32'(no_op));
        tick();
        chk($sformatf("%s rsp_valid drop", tag), 32'(rsp_valid), 32'h0);
        chk($sformatf("%s busy idle", tag), 32'(busy), 32'h0);
        chk($sformatf("%s rsp_data hold", tag), 32'(rsp_data), 32'(exp_d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = '0;
        for (int i = 0; i < int'(N); i++) begin
            req_opcode[i] = no_op;
            req_data[i]   = 16'h0000;
            req_key[i]    = 32'h0;
        end
        wave_pt[0] = 16'h1234; wave_pt[1] = 16'h5678; wave_pt[2] = 16'h9ABC; wave_pt[3] = 16'hDEF0;
        wave_exp[0][0] = 16'h2341; wave_exp[0][1] = 16'h6785;
        wave_exp[0][2] = 16'hABC9; wave_exp[0][3] = 16'hEF0D;
        wave_exp[1][0] = 16'h4123; wave_exp[1][1] = 16'h8567;
        wave_exp[1][2] = 16'hC9AB; wave_exp[1][3] = 16'h0DEF;

        // Reset values
        tick();
        tick();
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst req_ready", 32'(req_ready), 32'h0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst rsp_data", 32'(rsp_data), 32'h0);
        chk("rst rsp_err", 32'(rsp_err), 32'h0);
        chk("rst core_op", 32'(core_opcode), 32'(no_op));
        chk("rst core_din", 32'(core_data_in), 32'h0);
        chk("rst core_key", core_key, 32'h0);
        rst = 1'b1;
        tick();

        // Two full waves of simultaneous requests, key 0
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < int'(N); i++) begin
                req_opcode[i] = (w == 0) ? encrypt : decrypt;
                req_data[i]   = wave_pt[i];
                req_key[i]    = 32'h0;
            end
            req_valid = '1;
            for (int i = 0; i < int'(N); i++) begin
                serve(i, (w == 0) ? encrypt : decrypt, wave_exp[w][i], 1'b0, 4,
                      $sformatf("wave%0d r%0d", w, i));
            end
        end

        // Single encrypt, requester 0
        req_opcode[0] = encrypt; req_data[0] = 16'h1234; req_key[0] = 32'hDEADBEEF;
        req_valid = 4'b0001;
        serve(0, encrypt, 16'hB888, 1'b0, 4, "enc r0");

        // Decrypt of that ciphertext, requester 2
        req_opcode[2] = decrypt; req_data[2] = 16'hB888; req_key[2] = 32'hDEADBEEF;
        req_valid = 4'b0100;
        serve(2, decrypt, 16'h1234, 1'b0, 4, "dec r2");

        // Illegal opcode bypasses the core
        req_opcode[1] = no_op; req_data[1] = 16'h1111; req_key[1] = 32'h2222_3333;
        req_valid = 4'b0010;
        serve(1, no_op, 16'h0000, 1'b1, 2, "noop r1");

        // Core reports the wrong status
        force_bad = 1'b1;
        req_opcode[3] = encrypt; req_data[3] = 16'h1234; req_key[3] = 32'h0;
        req_valid = 4'b1000;
        serve(3, encrypt, 16'h0000, 1'b1, BAD_LAT, "bad r3");
        force_bad = 1'b0;

        // Pointer wrap: after requester 2, search resumes at 3 and wraps to 0 then 1
        req_opcode[2] = encrypt; req_data[2] = 16'h9ABC; req_key[2] = 32'h0;
        req_valid = 4'b0100;
        serve(2, encrypt, 16'hABC9, 1'b0, 4, "wrap r2");
        req_opcode[0] = encrypt; req_data[0] = 16'h1234; req_key[0] = 32'h0;
        req_opcode[1] = encrypt; req_data[1] = 16'h5678; req_key[1] = 32'h0;
        req_valid = 4'b0011;
        serve(0, encrypt, 16'h2341, 1'b0, 4, "wrap r0");
        serve(1, encrypt, 16'h6785, 1'b0, 4, "wrap r1");

        // Reset in WAIT aborts the operation and restarts arbitration from 0
        req_opcode[3] = encrypt; req_data[3] = 16'h5A5A; req_key[3] = 32'h0;
        req_valid = 4'b1000;
        #1;
        chk("abort ready", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        tick();
        chk("abort busy pre", 32'(busy), 32'h1);
        rst = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'h0);
        chk("abort rsp_valid", 32'(rsp_valid), 32'h0);
        chk("abort rsp_data", 32'(rsp_data), 32'h0);
        chk("abort rsp_err", 32'(rsp_err), 32'h0);
        chk("abort core_op", 32'(core_opcode), 32'(no_op));
        chk("abort core_din", 32'(core_data_in), 32'h0);
        chk("abort core_key", core_key, 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("abort quiet c%0d", c), 32'(rsp_valid), 32'h0);
        end
        rst = 1'b1;
        tick();
        req_opcode[1] = encrypt; req_data[1] = 16'h5678; req_key[1] = 32'h0;
        req_opcode[2] = encrypt; req_data[2] = 16'h9ABC; req_key[2] = 32'h0;
        req_valid = 4'b0110;
        serve(1, encrypt, 16'h6785, 1'b0, 4, "post r1");
        serve(2, encrypt, 16'hABC9, 1'b0, 4, "post r2");

`ifdef SPN_ARB_TIMEOUT_EN
        // Stalled core: error response TIMEOUT+2 cycles after ISSUE
        stall = 1'b1;
        req_opcode[0] = encrypt; req_data[0] = 16'h1234; req_key[0] = 32'h0;
        req_valid = 4'b0001;
        serve(0, encrypt, 16'h0000, 1'b1, TMO + 3, "stall r0");
        stall = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
